// File: rtl/npc_seq.sv
// Sequential next-PC unit: owns the PC register and sequences fetch addresses
// through branches, jumps, optional delay slots, exception entry and eret.
module npc_seq #(
   parameter int unsigned ADDR_W     = 32,
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_PC     = 32'h0000_4180,
   parameter bit          DELAY_SLOT = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [2:0]        op,
   input  logic              cond,
   input  logic [25:0]       imm26,
   input  logic [ADDR_W-1:0] ra,
   input  logic              exc,
   input  logic              eret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link,
   output logic [ADDR_W-1:0] epc,
   output logic              bd,
   output logic              in_slot,
   output logic              adel
);

   typedef enum logic [2:0] {
      OP_SEQ = 3'b000,
      OP_BR  = 3'b001,
      OP_J   = 3'b010,
      OP_JR  = 3'b011,
      OP_JAL = 3'b100
   } op_e;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              bd_q, bd_d;
   logic              pend_v_q, pend_v_d;

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] target;
   logic [31:0]       jmp32;
   logic              taken;

   assign pc4    = pc_q + ADDR_W'(4);
   assign br_off = ADDR_W'({{14{imm26[15]}}, imm26[15:0], 2'b00});

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      jmp32       = 32'(pc4);
      jmp32[27:0] = {imm26, 2'b00};
      target      = pc4;
      taken       = 1'b0;
      case (op)
         OP_BR:         begin target = pc4 + br_off;       taken = cond; end
         OP_J, OP_JAL:  begin target = jmp32[ADDR_W-1:0];  taken = 1'b1; end
         OP_JR:         begin target = ra;                 taken = 1'b1; end
         default:       begin target = pc4;                taken = 1'b0; end
      endcase
   end

   // A misaligned jr is suppressed in a delay slot because the slot's op is ignored anyway.
   assign adel = (op == OP_JR) && (ra[1:0] != 2'b00) && !pend_v_q;

   always_comb begin
      pc_d       = pc_q;
      epc_d      = epc_q;
      bd_d       = bd_q;
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      if (exc || adel) begin
         pc_d     = EXC_PC[ADDR_W-1:0];
         epc_d    = pend_v_q ? pc_q - ADDR_W'(4) : pc_q;
         bd_d     = pend_v_q;
         pend_v_d = 1'b0;
      end else if (!stall) begin
         if (eret) begin
            pc_d     = epc_q;
            pend_v_d = 1'b0;
         end else if (pend_v_q) begin
            pc_d     = pend_tgt_q;
            pend_v_d = 1'b0;
         end else if (taken && !DELAY_SLOT) begin
            pc_d = target;
         end else if (taken) begin
            pc_d       = pc4;
            pend_tgt_d = target;
            pend_v_d   = 1'b1;
         end else begin
            pc_d = pc4;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q       <= RESET_PC[ADDR_W-1:0];
         epc_q      <= '0;
         bd_q       <= 1'b0;
         pend_v_q   <= 1'b0;
         pend_tgt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         bd_q       <= bd_d;
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

   assign pc      = pc_q;
   assign epc     = epc_q;
   assign bd      = bd_q;
   assign in_slot = pend_v_q;
   assign link    = pc_q + (DELAY_SLOT ? ADDR_W'(8) : ADDR_W'(4));

endmodule

// File: tb/tb_npc_seq.sv
// Directed bench for npc_seq: one instance without and one with delay slots,
// expected register values queued per step and checked after the edge.
module tb_npc_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   [2];
   logic        stl   [2];
   logic [2:0]  op    [2];
   logic        cnd   [2];
   logic [25:0] imm   [2];
   logic [31:0] ra    [2];
   logic        exc   [2];
   logic        ert   [2];
   logic [31:0] pc_o  [2];
   logic [31:0] lnk_o [2];
   logic [31:0] epc_o [2];
   logic        bd_o  [2];
   logic        slt_o [2];
   logic        adl_o [2];

   npc_seq #(.DELAY_SLOT(1'b0)) u_ds0 (
      .clk(clk), .reset(rst[0]), .stall(stl[0]), .op(op[0]), .cond(cnd[0]),
      .imm26(imm[0]), .ra(ra[0]), .exc(exc[0]), .eret(ert[0]),
      .pc(pc_o[0]), .link(lnk_o[0]), .epc(epc_o[0]), .bd(bd_o[0]),
      .in_slot(slt_o[0]), .adel(adl_o[0])
   );

   npc_seq #(.DELAY_SLOT(1'b1)) u_ds1 (
      .clk(clk), .reset(rst[1]), .stall(stl[1]), .op(op[1]), .cond(cnd[1]),
      .imm26(imm[1]), .ra(ra[1]), .exc(exc[1]), .eret(ert[1]),
      .pc(pc_o[1]), .link(lnk_o[1]), .epc(epc_o[1]), .bd(bd_o[1]),
      .in_slot(slt_o[1]), .adel(adl_o[1])
   );

   localparam int S_PC = 0, S_EPC = 1, S_BD = 2, S_SLOT = 3, S_ADEL = 4, S_LINK = 5;

   typedef struct {
      string       tag;
      int          d;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   function automatic logic [31:0] observe(int d, int sel);
      case (sel)
         S_PC:    return pc_o[d];
         S_EPC:   return epc_o[d];
         S_BD:    return {31'b0, bd_o[d]};
         S_SLOT:  return {31'b0, slt_o[d]};
         S_ADEL:  return {31'b0, adl_o[d]};
         default: return lnk_o[d];
      endcase
   endfunction

   task automatic compare(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(int d, int sel, logic [31:0] v, string tag);
      sb.push_back('{tag: tag, d: d, sel: sel, exp: v});
   endtask

   // Combinational output check right after the inputs settle.
   task automatic now(int d, int sel, logic [31:0] v, string tag);
      #1;
      compare(tag, observe(d, sel), v);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         compare(e.tag, observe(e.d, e.sel), e.exp);
      end
   endtask

   task automatic drive(int d, logic r, logic s, logic [2:0] o, logic c,
                        logic [25:0] i, logic [31:0] a, logic x, logic er);
      @(negedge clk);
      rst[d] = r; stl[d] = s; op[d] = o; cnd[d] = c;
      imm[d] = i; ra[d]  = a; exc[d] = x; ert[d] = er;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; stl[d] = 1'b0; op[d] = 3'b000; cnd[d] = 1'b0;
         imm[d] = '0;   ra[d]  = '0;   exc[d] = 1'b0; ert[d] = 1'b0;
      end

      // ---------------- DELAY_SLOT = 0 ----------------
      drive(0, 0, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0);
      push(0, S_PC, 32'h3000, "ds0 reset pc");
      push(0, S_EPC, 32'h0, "ds0 reset epc");
      push(0, S_BD, 32'h0, "ds0 reset bd");
      push(0, S_SLOT, 32'h0, "ds0 reset in_slot");
      tick();
      now(0, S_ADEL, 32'h0, "ds0 reset adel");
      now(0, S_LINK, 32'h3004, "ds0 reset link");

      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h3004, "ds0 seq1"); tick();
      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h3008, "ds0 seq2"); tick();
      drive(0, 1, 0, 3'b111, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h300C, "ds0 op111 as seq"); tick();
      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h3010, "ds0 seq4"); tick();

      drive(0, 1, 0, 3'b001, 1, 26'h000FFFE, 32'h0, 0, 0); push(0, S_PC, 32'h300C, "ds0 branch taken back"); tick();
      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0);       push(0, S_PC, 32'h3010, "ds0 seq after branch"); tick();
      drive(0, 1, 0, 3'b001, 0, 26'h000FFFE, 32'h0, 0, 0); push(0, S_PC, 32'h3014, "ds0 branch not taken"); tick();

      drive(0, 1, 0, 3'b011, 0, 26'h0, 32'h3402, 0, 0);
      now(0, S_ADEL, 32'h1, "ds0 adel misaligned jr");
      push(0, S_PC, 32'h4180, "ds0 adel pc");
      push(0, S_EPC, 32'h3014, "ds0 adel epc");
      push(0, S_BD, 32'h0, "ds0 adel bd");
      tick();

      drive(0, 1, 0, 3'b011, 0, 26'h0, 32'h3400, 0, 0);
      now(0, S_ADEL, 32'h0, "ds0 aligned jr adel");
      push(0, S_PC, 32'h3400, "ds0 jr pc"); tick();

      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 1); push(0, S_PC, 32'h3014, "ds0 eret pc"); tick();
      drive(0, 1, 0, 3'b010, 0, 26'h0000C40, 32'h0, 0, 0); push(0, S_PC, 32'h3100, "ds0 j pc"); tick();

      drive(0, 1, 1, 3'b010, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h3100, "ds0 stall hold 1"); tick();
      drive(0, 1, 1, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h3100, "ds0 stall hold 2"); tick();
      drive(0, 1, 1, 3'b000, 0, 26'h0, 32'h0, 1, 0);
      push(0, S_PC, 32'h4180, "ds0 exc under stall pc");
      push(0, S_EPC, 32'h3100, "ds0 exc under stall epc");
      tick();

      drive(0, 1, 0, 3'b011, 0, 26'h0, 32'hFFFF_FFFC, 0, 0); push(0, S_PC, 32'hFFFF_FFFC, "ds0 jr to top"); tick();
      now(0, S_LINK, 32'h0, "ds0 link wraps");
      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(0, S_PC, 32'h0, "ds0 pc wraps to 0"); tick();

      drive(0, 1, 0, 3'b010, 0, 26'h0000040, 32'h0, 0, 1); push(0, S_PC, 32'h3100, "ds0 eret beats j"); tick();
      drive(0, 1, 0, 3'b000, 0, 26'h0, 32'h0, 1, 1);
      push(0, S_PC, 32'h4180, "ds0 exc beats eret pc");
      push(0, S_EPC, 32'h3100, "ds0 exc beats eret epc");
      tick();

      // ---------------- DELAY_SLOT = 1 ----------------
      drive(1, 0, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0);
      push(1, S_PC, 32'h3000, "ds1 reset pc");
      push(1, S_SLOT, 32'h0, "ds1 reset in_slot");
      tick();

      drive(1, 1, 0, 3'b100, 0, 26'h0000C40, 32'h0, 0, 0);
      now(1, S_LINK, 32'h3008, "ds1 jal link");
      push(1, S_PC, 32'h3004, "ds1 jal slot pc");
      push(1, S_SLOT, 32'h1, "ds1 jal in_slot");
      tick();
      drive(1, 1, 0, 3'b010, 0, 26'h0, 32'h0, 0, 0);
      push(1, S_PC, 32'h3100, "ds1 jal target, slot j ignored");
      push(1, S_SLOT, 32'h0, "ds1 slot cleared");
      tick();

      drive(1, 1, 0, 3'b010, 0, 26'h0000C00, 32'h0, 0, 0);
      push(1, S_PC, 32'h3104, "ds1 j slot pc");
      push(1, S_SLOT, 32'h1, "ds1 j in_slot");
      tick();
      drive(1, 0, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0);
      push(1, S_PC, 32'h3000, "ds1 reset in slot pc");
      push(1, S_SLOT, 32'h0, "ds1 reset clears pend");
      tick();

      drive(1, 1, 0, 3'b100, 0, 26'h0000C40, 32'h0, 0, 0);
      push(1, S_PC, 32'h3004, "ds1 no stale redirect");
      push(1, S_SLOT, 32'h1, "ds1 jal in_slot again");
      tick();
      drive(1, 1, 0, 3'b000, 0, 26'h0, 32'h0, 1, 0);
      push(1, S_PC, 32'h4180, "ds1 exc in slot pc");
      push(1, S_EPC, 32'h3000, "ds1 exc in slot epc");
      push(1, S_BD, 32'h1, "ds1 exc in slot bd");
      push(1, S_SLOT, 32'h0, "ds1 exc clears slot");
      tick();
      drive(1, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 1);
      push(1, S_PC, 32'h3000, "ds1 eret pc");
      push(1, S_BD, 32'h1, "ds1 eret keeps bd");
      tick();

      drive(1, 1, 0, 3'b010, 0, 26'h0000C40, 32'h0, 0, 0); push(1, S_SLOT, 32'h1, "ds1 j before stall"); tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 1, 3'b000, 0, 26'h0, 32'h0, 0, 0);
         push(1, S_PC, 32'h3004, $sformatf("ds1 stall %0d pc", k));
         push(1, S_SLOT, 32'h1, $sformatf("ds1 stall %0d in_slot", k));
         tick();
      end
      drive(1, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0);
      push(1, S_PC, 32'h3100, "ds1 redirect after stall");
      push(1, S_SLOT, 32'h0, "ds1 slot done after stall");
      tick();

      drive(1, 1, 0, 3'b010, 0, 26'h0000C40, 32'h0, 0, 0); push(1, S_PC, 32'h3104, "ds1 j slot 2"); tick();
      drive(1, 1, 1, 3'b000, 0, 26'h0, 32'h0, 1, 0);
      push(1, S_PC, 32'h4180, "ds1 exc in stalled slot pc");
      push(1, S_EPC, 32'h3100, "ds1 exc in stalled slot epc");
      push(1, S_BD, 32'h1, "ds1 exc in stalled slot bd");
      push(1, S_SLOT, 32'h0, "ds1 exc in stalled slot in_slot");
      tick();
      drive(1, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(1, S_PC, 32'h4184, "ds1 seq after exc"); tick();
      drive(1, 1, 0, 3'b001, 0, 26'h0000001, 32'h0, 0, 0);
      push(1, S_PC, 32'h4188, "ds1 branch not taken");
      push(1, S_SLOT, 32'h0, "ds1 not taken no slot");
      tick();
      drive(1, 1, 0, 3'b001, 1, 26'h0000001, 32'h0, 0, 0);
      push(1, S_PC, 32'h418C, "ds1 branch taken slot pc");
      push(1, S_SLOT, 32'h1, "ds1 branch taken in_slot");
      tick();
      drive(1, 1, 0, 3'b000, 0, 26'h0, 32'h0, 0, 0); push(1, S_PC, 32'h4190, "ds1 branch target"); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
